bcd_updown_counter_n: RTL and testbench

//   Parametrised N-digit BCD up/down counter: synchronous parallel load, count enable,

---
 rtl/bcd_pkg.sv | 12 +
 rtl/bcd_digit_cell.sv | 31 +++
 rtl/bcd_updown_counter_n.sv | 72 +++++++
 tb/tb_bcd_updown_counter_n.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared constants and helpers for the BCD counter slice.
package bcd_pkg;

  localparam logic [3:0] BCD_MAX = 4'd9;
  localparam logic [3:0] BCD_MIN = 4'd0;

  // True when a nibble holds a legal decimal digit.
  function automatic bit is_bcd(input logic [3:0] nib);
    return (nib <= BCD_MAX);
  endfunction

endpackage : bcd_pkg

// File: rtl/bcd_digit_cell.sv
// One BCD digit: load, step up/down with 9<->0 rollover, and extreme-value flags.
module bcd_digit_cell
  import bcd_pkg::*;
(
  input  logic       clk,
  input  logic       clr,
  input  logic       step,
  input  logic       up,
  input  logic       ld,
  input  logic [3:0] d,
  output logic [3:0] q,
  output logic       at_max,
  output logic       at_min
);

  // Digit register: clear > load > step > hold.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      q <= BCD_MIN;
    end else if (ld) begin
      q <= d;
    end else if (step) begin
      if (up) q <= (q == BCD_MAX) ? BCD_MIN : q + 4'd1;
      else    q <= (q == BCD_MIN) ? BCD_MAX : q - 4'd1;
    end
  end

  assign at_max = (q == BCD_MAX);
  assign at_min = (q == BCD_MIN);

endmodule : bcd_digit_cell

// File: rtl/bcd_updown_counter_n.sv
// N-digit BCD up/down counter with parallel load, wrap/saturate terminal
// handling, combinational terminal count and a rejected-load pulse.
module bcd_updown_counter_n
  import bcd_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter bit SATURATE = 1'b0
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  en,
  input  logic                  load,
  input  logic                  up,
  input  logic [4*DIGITS-1:0]   d,
  output logic [4*DIGITS-1:0]   q,
  output logic                  tc,
  output logic                  load_err
);

  logic [DIGITS-1:0] at_max;
  logic [DIGITS-1:0] at_min;
  logic [DIGITS-1:0] step;
  // pref_*[i] = all digits below i are at their extreme; pref_*[DIGITS] covers the whole word.
  logic [DIGITS:0]   pref_max;
  logic [DIGITS:0]   pref_min;
  logic              terminal;
  logic              count_go;
  logic              load_ok;
  logic              ld_digit;

  assign pref_max[0] = 1'b1;
  assign pref_min[0] = 1'b1;

  // A load is only accepted when every digit is decimal; otherwise nothing moves.
  always_comb begin
    load_ok = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (!is_bcd(d[4*i +: 4])) load_ok = 1'b0;
    end
  end

  assign ld_digit = load & load_ok;
  assign terminal = up ? pref_max[DIGITS] : pref_min[DIGITS];
  // Saturating counters simply refuse to step at the terminal value.
  assign count_go = en & ~load & ~(SATURATE & terminal);
  assign tc       = en & ~load & terminal;

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    assign pref_max[g+1] = pref_max[g] & at_max[g];
    assign pref_min[g+1] = pref_min[g] & at_min[g];
    assign step[g]       = count_go & (up ? pref_max[g] : pref_min[g]);

    bcd_digit_cell u_cell (
      .clk    (clk),
      .clr    (clr),
      .step   (step[g]),
      .up     (up),
      .ld     (ld_digit),
      .d      (d[4*g +: 4]),
      .q      (q[4*g +: 4]),
      .at_max (at_max[g]),
      .at_min (at_min[g])
    );
  end

  // Rejected-load flag: high for exactly the cycle after a bad load.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) load_err <= 1'b0;
    else     load_err <= load & ~load_ok;
  end

endmodule : bcd_updown_counter_n

// File: tb/tb_bcd_updown_counter_n.sv
module tb_bcd_updown_counter_n;

  localparam int DIGITS = 4;
  localparam int MAXV   = 9999;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic        en = 1'b0, load = 1'b0, up = 1'b0;
  logic [15:0] d = '0;
  logic [15:0] q0, q1;
  logic        tc0, tc1, err0, err1;

  int n_checks = 0;
  int n_fail   = 0;

  // reference state: plain integers
  int v0 = 0, v1 = 0;
  bit e_err = 1'b0;

  always #5 clk = ~clk;

  bcd_updown_counter_n #(.DIGITS(DIGITS), .SATURATE(1'b0)) u_wrap (
    .clk(clk), .clr(clr), .en(en), .load(load), .up(up), .d(d),
    .q(q0), .tc(tc0), .load_err(err0));

  bcd_updown_counter_n #(.DIGITS(DIGITS), .SATURATE(1'b1)) u_sat (
    .clk(clk), .clr(clr), .en(en), .load(load), .up(up), .d(d),
    .q(q1), .tc(tc1), .load_err(err1));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    int t;
    t = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic bit bcd_valid(input logic [15:0] x);
    for (int i = 0; i < DIGITS; i++)
      if (x[4*i +: 4] > 4'd9) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int bcd_to_int(input logic [15:0] x);
    int r;
    r = 0;
    for (int i = DIGITS - 1; i >= 0; i--) r = r * 10 + int'(x[4*i +: 4]);
    return r;
  endfunction

  function automatic bit exp_tc(input int v);
    return en && !load && (up ? (v == MAXV) : (v == 0));
  endfunction

  function automatic int next_val(input int v, input bit sat);
    if (load) return bcd_valid(d) ? bcd_to_int(d) : v;
    if (!en) return v;
    if (up)  return (v == MAXV) ? (sat ? v : 0) : v + 1;
    return (v == 0) ? (sat ? v : MAXV) : v - 1;
  endfunction

  task automatic cyc(input bit e, input bit l, input bit u, input logic [15:0] dv);
    @(negedge clk);
    en = e; load = l; up = u; d = dv;
    #1;
    chk("tc_wrap", 32'(tc0), 32'(exp_tc(v0)));
    chk("tc_sat",  32'(tc1), 32'(exp_tc(v1)));
    @(posedge clk);
    v0 = next_val(v0, 1'b0);
    v1 = next_val(v1, 1'b1);
    e_err = load && !bcd_valid(d);
    #1;
    chk("q_wrap",   32'(q0),   32'(to_bcd(v0)));
    chk("q_sat",    32'(q1),   32'(to_bcd(v1)));
    chk("err_wrap", 32'(err0), 32'(e_err));
    chk("err_sat",  32'(err1), 32'(e_err));
  endtask

  function automatic logic [15:0] rand_d();
    logic [15:0] r;
    int sel;
    sel = $urandom_range(0, 9);
    if (sel == 0) return 16'h9999;
    if (sel == 1) return 16'h0000;
    if (sel == 2) return 16'h0999;
    for (int i = 0; i < DIGITS; i++)
      r[4*i +: 4] = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(10, 15))
                                                 : 4'($urandom_range(0, 9));
    return r;
  endfunction

  initial begin
    // reset state while clr held across edges
    #1;
    chk("rst_q_wrap", 32'(q0), 32'h0);
    chk("rst_q_sat",  32'(q1), 32'h0);
    chk("rst_err",    32'(err0), 32'h0);
    @(posedge clk); #1;
    chk("rst_hold_q", 32'(q0), 32'h0);
    @(negedge clk); clr = 1'b0;

    // 1: count to 0123, bad load to raise load_err, then async clear mid-cycle
    cyc(1'b0, 1'b1, 1'b1, 16'h0000);
    for (int i = 0; i < 123; i++) cyc(1'b1, 1'b0, 1'b1, 16'h0000);
    cyc(1'b0, 1'b1, 1'b1, 16'h00A0);
    #2 clr = 1'b1;
    #1;
    chk("aclr_q_wrap", 32'(q0), 32'h0);
    chk("aclr_q_sat",  32'(q1), 32'h0);
    chk("aclr_err",    32'(err0), 32'h0);
    v0 = 0; v1 = 0; e_err = 1'b0;
    @(negedge clk); en = 1'b1; up = 1'b1; load = 1'b0;
    @(posedge clk); #1;
    chk("clr_held_q", 32'(q0), 32'h0);
    @(negedge clk); en = 1'b0; clr = 1'b0;

    // 2: carry across three digits
    cyc(1'b0, 1'b1, 1'b1, 16'h0999);
    cyc(1'b1, 1'b0, 1'b1, 16'h0000);
    chk("carry_0999", 32'(q0), 32'h1000);

    // 3: up terminal, wrap vs saturate
    cyc(1'b0, 1'b1, 1'b1, 16'h9999);
    cyc(1'b1, 1'b0, 1'b1, 16'h0000);
    cyc(1'b1, 1'b0, 1'b1, 16'h0000);
    chk("sat_hold", 32'(q1), 32'h9999);

    // 4: borrow and down terminal
    cyc(1'b0, 1'b1, 1'b0, 16'h1000);
    cyc(1'b1, 1'b0, 1'b0, 16'h0000);
    chk("borrow_1000", 32'(q0), 32'h0999);
    cyc(1'b0, 1'b1, 1'b0, 16'h0000);
    cyc(1'b1, 1'b0, 1'b0, 16'h0000);
    chk("down_wrap", 32'(q0), 32'h9999);

    // 5: rejected load leaves q, one-cycle error pulse, then good load
    cyc(1'b0, 1'b1, 1'b1, 16'h0456);
    cyc(1'b1, 1'b1, 1'b1, 16'h12A4);
    chk("rej_hold", 32'(q0), 32'h0456);
    cyc(1'b0, 1'b0, 1'b1, 16'h0000);
    cyc(1'b0, 1'b1, 1'b1, 16'h1234);

    // 6: load wins over count, then hold with en low
    cyc(1'b1, 1'b1, 1'b1, 16'h0042);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'($urandom_range(0, 1)), 16'h0000);
    chk("hold_0042", 32'(q0), 32'h0042);

    // random traffic
    for (int i = 0; i < 1500; i++)
      cyc(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 9) == 0),
          1'($urandom_range(0, 1)), rand_d());

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_bcd_updown_counter_n
